// File: rtl/cpu_mon_pkg.sv
// cpu_mon_pkg: shared FSM states, check-entry struct and reset constants for cpu_run_monitor.
package cpu_mon_pkg;
    localparam int MON_AW = 64;
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_e;
    typedef struct packed {
        logic              is_mem;
        logic [MON_AW-1:0] addr;
        logic [MON_AW-1:0] value;
    } check_t;
    localparam state_e      STATE_RST = IDLE;
    localparam logic [31:0] CYCLE_RST = '0;
endpackage

// File: rtl/cpu_mon_shadow.sv
// cpu_mon_shadow: per-check write matcher and shadow register.
// CPU_MON_STRICT_EN adds a written flag that forces a mismatch for untouched checks.
module cpu_mon_shadow
    import cpu_mon_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            run_i,
    input  logic            rf_we_i,
    input  logic [4:0]      rf_waddr_i,
    input  logic [XLEN-1:0] rf_wdata_i,
    input  logic            dmem_we_i,
    input  logic [XLEN-1:0] dmem_addr_i,
    input  logic [XLEN-1:0] dmem_wdata_i,
    input  check_t          ent_i,
    output logic            mismatch_o
);
    logic [XLEN-1:0] shadow_q, shadow_d;
    logic hit_rf, hit_mem, unused_bits;
    assign hit_rf  = run_i && !ent_i.is_mem && rf_we_i && rf_waddr_i != 5'd0 && ent_i.addr[4:0] == rf_waddr_i;
    assign hit_mem = run_i && ent_i.is_mem && dmem_we_i && ent_i.addr[XLEN-1:2] == dmem_addr_i[XLEN-1:2];
    assign unused_bits = ^dmem_addr_i[1:0];
    if (XLEN < MON_AW) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^{ent_i.addr[MON_AW-1:XLEN], ent_i.value[MON_AW-1:XLEN]};
    end
    always_comb shadow_d = clear_i ? '0 : hit_rf ? rf_wdata_i : hit_mem ? dmem_wdata_i : shadow_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_q <= '0;
        else     shadow_q <= shadow_d;
    end
`ifdef CPU_MON_STRICT_EN
    logic written_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) written_q <= 1'b0;
        else     written_q <= !clear_i && (written_q || hit_rf || hit_mem);
    end
    assign mismatch_o = shadow_q != ent_i.value[XLEN-1:0] || !written_q;
`else
    assign mismatch_o = shadow_q != ent_i.value[XLEN-1:0];
`endif
endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: runs a core until a pc self-loop or cycle limit, then checks final reg/mem values.
// Optional CPU_MON_STRICT_EN: checks never written during RUN also fail.
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int HALT_REPEAT    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [XLEN-1:0]            pc,
    input  logic                       rf_we,
    input  logic [4:0]                 rf_waddr,
    input  logic [XLEN-1:0]            rf_wdata,
    input  logic                       dmem_we,
    input  logic [XLEN-1:0]            dmem_addr,
    input  logic [XLEN-1:0]            dmem_wdata,
    input  logic [NUM_CHECKS-1:0]      exp_is_mem,
    input  logic [NUM_CHECKS*XLEN-1:0] exp_addr,
    input  logic [NUM_CHECKS*XLEN-1:0] exp_value,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [NUM_CHECKS-1:0]      fail_mask,
    output logic [31:0]                cycle_count
);
    localparam int IW = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1;
    localparam int HW = $clog2(HALT_REPEAT + 1);
    localparam logic [IW-1:0] LAST  = IW'(NUM_CHECKS - 1);
    localparam logic [HW-1:0] HR_M1 = HW'(HALT_REPEAT - 1);
    localparam logic [31:0]   TO    = 32'(TIMEOUT_CYCLES);
    state_e                state_q, state_d;
    logic [31:0]           cycle_q, cycle_d;
    logic [NUM_CHECKS-1:0] fail_q, fail_d, mism;
    logic                  timeout_q, timeout_d, pc_vld_q, pc_vld_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [XLEN-1:0]       prev_pc_q, prev_pc_d;
    logic [HW-1:0]         rep_q, rep_d;
    logic in_run, launch, same, halt;
    assign in_run = state_q == RUN;
    assign launch = start && (state_q == IDLE || state_q == DONE);
    assign same   = in_run && pc_vld_q && pc == prev_pc_q;
    assign halt   = same && rep_q >= HR_M1;
    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        idx_d     = idx_q;
        prev_pc_d = prev_pc_q;
        pc_vld_d  = pc_vld_q;
        rep_d     = rep_q;
        if (launch) begin
            state_d   = RUN;
            cycle_d   = '0;
            fail_d    = '0;
            timeout_d = 1'b0;
            idx_d     = '0;
            pc_vld_d  = 1'b0;
            rep_d     = '0;
        end else if (in_run) begin
            cycle_d   = cycle_q + 32'd1;
            prev_pc_d = pc;
            pc_vld_d  = 1'b1;
            rep_d     = same ? rep_q + HW'(1) : '0;
            // halt wins over a timeout landing on the same cycle
            if (halt) state_d = CHECK;
            else if (cycle_d == TO) begin
                state_d   = DONE;
                timeout_d = 1'b1;
            end
        end else if (state_q == CHECK) begin
            fail_d[idx_q] = mism[idx_q];
            idx_d         = idx_q + IW'(1);
            state_d       = idx_q == LAST ? DONE : CHECK;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= STATE_RST;
            cycle_q   <= CYCLE_RST;
            fail_q    <= '0;
            timeout_q <= 1'b0;
            idx_q     <= '0;
            prev_pc_q <= '0;
            pc_vld_q  <= 1'b0;
            rep_q     <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            idx_q     <= idx_d;
            prev_pc_q <= prev_pc_d;
            pc_vld_q  <= pc_vld_d;
            rep_q     <= rep_d;
        end
    end
    for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_chk
        check_t ent;
        assign ent = '{is_mem: exp_is_mem[i],
                       addr:   MON_AW'(exp_addr[i*XLEN +: XLEN]),
                       value:  MON_AW'(exp_value[i*XLEN +: XLEN])};
        cpu_mon_shadow #(.XLEN(XLEN)) u_shadow (
            .clk         (clk),
            .rst         (rst),
            .clear_i     (launch),
            .run_i       (in_run),
            .rf_we_i     (rf_we),
            .rf_waddr_i  (rf_waddr),
            .rf_wdata_i  (rf_wdata),
            .dmem_we_i   (dmem_we),
            .dmem_addr_i (dmem_addr),
            .dmem_wdata_i(dmem_wdata),
            .ent_i       (ent),
            .mismatch_o  (mism[i])
        );
    end
    assign busy        = state_q == RUN || state_q == CHECK;
    assign done        = state_q == DONE;
    assign pass        = done && !timeout_q && fail_q == '0;
    assign timeout     = timeout_q;
    assign fail_mask   = fail_q;
    assign cycle_count = cycle_q;
endmodule
